stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// LIFO stack controller over an external 2**ADDR_BITS x 4 memory; STACK_ERROR_FLAGS_EN adds overflow/underflow.
// Latency: PUSH takes one busy cycle (WR); POP takes two (RD, CAP), and pop_valid pulses two edges after acceptance.
// Backpressure: cmd_ready is high only in IDLE; full/empty make PUSH/POP no-ops rather than stalling.

`ifndef MEMORY_ADDR_BITS
`define MEMORY_ADDR_BITS 4
`endif
`ifndef MEMORY_MODE_READ
`define MEMORY_MODE_READ 2'b00
`endif
`ifndef MEMORY_MODE_WRITE
`define MEMORY_MODE_WRITE 2'b01
`endif
`ifndef MEMORY_MODE_CLEAR
`define MEMORY_MODE_CLEAR 2'b10
`endif

module stack_ctrl #(
  parameter int ADDR_BITS = `MEMORY_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           push_data,
  output logic [3:0]           pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   depth,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [3:0]           mem_data_in,
  input  logic [3:0]           mem_data_out
`ifdef STACK_ERROR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam logic [1:0] CMD_PUSH  = 2'b01;
  localparam logic [1:0] CMD_POP   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [ADDR_BITS:0]   ONE_S = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CAP_S = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    WR,
    RD,
    CAP
  } state_t;

  state_t                 state;
  logic [ADDR_BITS:0]     sp;
  logic [ADDR_BITS-1:0]   sp_lo;
  logic [ADDR_BITS-1:0]   sp_m1;
  logic                   accept;

  assign sp_lo  = sp[ADDR_BITS-1:0];
  assign sp_m1  = sp_lo - ONE_A;
  assign depth  = sp;
  assign full   = (sp == CAP_S);
  assign empty  = (sp == '0);
  assign accept = cmd_valid && cmd_ready && (state == IDLE);

  // mem_address is kept registered so that in IDLE it always reads the top entry (sp-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLR;
      sp          <= '0;
      pop_data    <= 4'h0;
      pop_valid   <= 1'b0;
      cmd_ready   <= 1'b0;
      mem_mode    <= `MEMORY_MODE_CLEAR;
      mem_address <= '0;
      mem_data_in <= 4'h0;
`ifdef STACK_ERROR_FLAGS_EN
      overflow    <= 1'b0;
      underflow   <= 1'b0;
`endif
    end else begin
      pop_valid <= 1'b0;
      case (state)
        CLR: begin
          sp          <= '0;
          pop_data    <= 4'h0;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          mem_mode    <= `MEMORY_MODE_READ;
          mem_address <= {ADDR_BITS{1'b1}};
        end
        IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_PUSH: begin
                if (!full) begin
                  state       <= WR;
                  cmd_ready   <= 1'b0;
                  mem_mode    <= `MEMORY_MODE_WRITE;
                  mem_address <= sp_lo;
                  mem_data_in <= push_data;
                end
`ifdef STACK_ERROR_FLAGS_EN
                else begin
                  overflow <= 1'b1;
                end
`endif
              end
              CMD_POP: begin
                if (!empty) begin
                  sp          <= sp - ONE_S;
                  state       <= RD;
                  cmd_ready   <= 1'b0;
                  mem_address <= sp_m1;
                end
`ifdef STACK_ERROR_FLAGS_EN
                else begin
                  underflow <= 1'b1;
                end
`endif
              end
              CMD_CLEAR: begin
                state     <= CLR;
                cmd_ready <= 1'b0;
                mem_mode  <= `MEMORY_MODE_CLEAR;
`ifdef STACK_ERROR_FLAGS_EN
                overflow  <= 1'b0;
                underflow <= 1'b0;
`endif
              end
              default: begin
              end
            endcase
          end
        end
        WR: begin
          sp          <= sp + ONE_S;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          mem_mode    <= `MEMORY_MODE_READ;
          mem_address <= sp_lo;
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          // sp was already decremented at acceptance, so sp_m1 is the new top.
          pop_data    <= mem_data_out;
          pop_valid   <= 1'b1;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          mem_address <= sp_m1;
        end
        default: begin
          state     <= CLR;
          cmd_ready <= 1'b0;
          mem_mode  <= `MEMORY_MODE_CLEAR;
        end
      endcase
    end
  end

endmodule
